// File: rtl/spart_key_rx.sv
// Serial keyboard front end: 8N1 receiver, key-code decode and a small FIFO
// that hands keys to the CPU as single-cycle SPART_we strobes.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | line idle, waiting for a low level on the synchronized rxd
// START   | start bit seen; re-check it at mid-bit (8th tick)
// DATA    | sampling 8 data bits, LSB first, every 16 ticks
// STOP    | sampling the stop bit 16 ticks after the last data bit
// BREAK   | bad stop bit; wait for the line to return high
module spart_key_rx #(
  parameter int DIV        = 54,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       cpu_rdy,
  output logic       SPART_we,
  output logic [3:0] SPART_keys,
  output logic       frame_err,
  output logic       overflow,
  output logic       rx_busy
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  logic          r_rxd_meta;
  logic          r_rxd_sync;
  logic [TW-1:0] r_tick_cnt;
  logic          w_tick;
  logic          w_start_edge;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [3:0]    r_sub;
  logic [3:0]    w_sub_nxt;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          w_byte_vld;
  logic          w_frame_err;
  logic          r_byte_vld;
  logic          r_frame_err;

  logic          w_key_hit;
  logic [3:0]    w_key_map;
  logic          r_key_vld;
  logic [3:0]    r_key_code;

  logic [3:0]    r_mem [FIFO_DEPTH];
  logic [AW:0]   r_wptr;
  logic [AW:0]   r_rptr;
  logic          w_empty;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;

  logic          r_we;
  logic [3:0]    r_keys;
  logic          r_overflow;

  // Sync flops reset high so a reset never looks like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
    end else begin
      r_rxd_meta <= rxd;
      r_rxd_sync <= r_rxd_meta;
    end
  end

  assign w_start_edge = (r_state == ST_IDLE) && !r_rxd_sync;
  assign w_tick       = (r_tick_cnt == TW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || w_start_edge || w_tick) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_sub       <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_sub       <= w_sub_nxt;
      r_bit       <= w_bit_nxt;
      r_shift     <= w_shift_nxt;
      r_byte_vld  <= w_byte_vld;
      r_frame_err <= w_frame_err;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sub_nxt   = r_sub;
    w_bit_nxt   = r_bit;
    w_shift_nxt = r_shift;
    w_byte_vld  = 1'b0;
    w_frame_err = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!r_rxd_sync) begin
          w_state_nxt = ST_START;
          w_sub_nxt   = '0;
        end
      end
      ST_START: begin
        if (w_tick) begin
          if (r_sub == 4'd7) begin
            w_sub_nxt = '0;
            if (!r_rxd_sync) begin
              w_state_nxt = ST_DATA;
              w_bit_nxt   = '0;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_sub_nxt = r_sub + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_sub == 4'd15) begin
            w_sub_nxt          = '0;
            w_shift_nxt[r_bit] = r_rxd_sync;
            if (r_bit == 3'd7) begin
              w_state_nxt = ST_STOP;
            end else begin
              w_bit_nxt = r_bit + 3'd1;
            end
          end else begin
            w_sub_nxt = r_sub + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          if (r_sub == 4'd15) begin
            w_sub_nxt = '0;
            if (r_rxd_sync) begin
              w_byte_vld  = 1'b1;
              w_state_nxt = ST_IDLE;
            end else begin
              w_frame_err = 1'b1;
              w_state_nxt = ST_BREAK;
            end
          end else begin
            w_sub_nxt = r_sub + 4'd1;
          end
        end
      end
      ST_BREAK: begin
        if (r_rxd_sync) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_key_hit = 1'b1;
    w_key_map = 4'd0;
    unique case (r_shift)
      8'h77, 8'h57: w_key_map = 4'd1;
      8'h73, 8'h53: w_key_map = 4'd2;
      8'h61, 8'h41: w_key_map = 4'd3;
      8'h64, 8'h44: w_key_map = 4'd4;
      8'h71, 8'h51: w_key_map = 4'd5;
      8'h65, 8'h45: w_key_map = 4'd6;
      8'h20:        w_key_map = 4'd7;
      8'h0D:        w_key_map = 4'd8;
      default:      w_key_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_vld  <= 1'b0;
      r_key_code <= '0;
    end else begin
      r_key_vld  <= r_byte_vld && w_key_hit;
      r_key_code <= w_key_map;
    end
  end

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  // r_we gating keeps at least one idle cycle between strobes.
  assign w_pop   = !w_empty && cpu_rdy && !r_we;
  assign w_push  = r_key_vld && (!w_full || w_pop);
  assign w_drop  = r_key_vld && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr[AW-1:0]] <= r_key_code;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + (AW+1)'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + (AW+1)'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we   <= 1'b0;
      r_keys <= '0;
    end else begin
      r_we <= w_pop;
      if (w_pop) begin
        r_keys <= r_mem[r_rptr[AW-1:0]];
      end
    end
  end

  assign SPART_we   = r_we;
  assign SPART_keys = r_keys;
  assign frame_err  = r_frame_err;
  assign overflow   = r_overflow;
  assign rx_busy    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_spart_key_rx.sv
// Directed bench for spart_key_rx: serial bytes in, key strobes checked
// against hand-computed codes, latency, error and overflow behaviour.
module tb_spart_key_rx;

  localparam int DIV      = 4;
  localparam int BIT_CLKS = 16 * DIV;
  // start drive -> SPART_we: 2 sync + 1 detect + (8+16*9) ticks * DIV + 3
  localparam int LATENCY  = 614;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic       cpu_rdy;
  logic       SPART_we;
  logic [3:0] SPART_keys;
  logic       frame_err;
  logic       overflow;
  logic       rx_busy;

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         n_ferr = 0;
  int         n_b2b = 0;
  logic       prev_we = 1'b0;
  logic [3:0] q_keys[$];
  int         q_cyc[$];

  spart_key_rx #(.DIV(DIV), .FIFO_DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .rxd        (rxd),
    .cpu_rdy    (cpu_rdy),
    .SPART_we   (SPART_we),
    .SPART_keys (SPART_keys),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .rx_busy    (rx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst) begin
      prev_we = 1'b0;
    end else begin
      if (SPART_we) begin
        q_keys.push_back(SPART_keys);
        q_cyc.push_back(cyc);
        if (prev_we) n_b2b++;
      end
      if (frame_err) n_ferr++;
      prev_we = SPART_we;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit, output int t_start);
    @(posedge clk);
    #1;
    t_start = cyc;
    rxd = 1'b0;
    idle(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(BIT_CLKS);
    end
    rxd = stop_bit;
    idle(BIT_CLKS);
  endtask

  initial begin
    int         t0;
    int         bk;
    int         bf;
    int         bb;
    logic [7:0] w_bytes[5];
    logic [3:0] exp_keys[4];
    logic [7:0] b6;
    w_bytes  = '{8'h77, 8'h73, 8'h61, 8'h64, 8'h71};
    exp_keys = '{4'd1, 4'd2, 4'd3, 4'd4};
    b6       = 8'h77;

    rst = 1'b1;
    rxd = 1'b1;
    cpu_rdy = 1'b1;
    idle(5);
    rst = 1'b0;
    @(negedge clk);
    check("rst_we", 32'(SPART_we), 32'd0);
    check("rst_keys", 32'(SPART_keys), 32'd0);
    check("rst_ferr", 32'(frame_err), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_busy", 32'(rx_busy), 32'd0);
    idle(20);

    // 1: single 'w'
    bk = q_keys.size(); bf = n_ferr;
    send_byte(8'h77, 1'b1, t0);
    idle(200);
    check("t1_npulse", q_keys.size() - bk, 1);
    if (q_keys.size() > bk) begin
      check("t1_key", 32'(q_keys[bk]), 32'd1);
      check("t1_latency", q_cyc[bk] - t0, LATENCY);
    end
    check("t1_ferr", n_ferr - bf, 0);
    check("t1_ovf", 32'(overflow), 32'd0);

    // 2: unmapped byte then space
    bk = q_keys.size();
    send_byte(8'h78, 1'b1, t0);
    idle(100);
    check("t2_unmapped", q_keys.size() - bk, 0);
    send_byte(8'h20, 1'b1, t0);
    idle(100);
    check("t2_npulse", q_keys.size() - bk, 1);
    if (q_keys.size() > bk) check("t2_key", 32'(q_keys[bk]), 32'd7);

    // 3: bad stop bit with held-low line, then recovery
    bk = q_keys.size(); bf = n_ferr;
    send_byte(8'h64, 1'b0, t0);
    idle(40 * BIT_CLKS);
    check("t3_busy_break", 32'(rx_busy), 32'd1);
    rxd = 1'b1;
    idle(200);
    check("t3_ferr", n_ferr - bf, 1);
    check("t3_nopulse", q_keys.size() - bk, 0);
    check("t3_busy_idle", 32'(rx_busy), 32'd0);
    send_byte(8'h61, 1'b1, t0);
    idle(100);
    check("t3_npulse", q_keys.size() - bk, 1);
    if (q_keys.size() > bk) check("t3_key", 32'(q_keys[bk]), 32'd3);
    check("t3_ferr_after", n_ferr - bf, 1);

    // 4: glitch of 5 ticks
    bk = q_keys.size(); bf = n_ferr;
    @(posedge clk); #1;
    rxd = 1'b0;
    idle(5 * DIV);
    check("t4_busy_high", 32'(rx_busy), 32'd1);
    rxd = 1'b1;
    idle(100);
    check("t4_busy_low", 32'(rx_busy), 32'd0);
    check("t4_ferr", n_ferr - bf, 0);
    check("t4_nopulse", q_keys.size() - bk, 0);

    // 5: overflow with CPU stalled
    bk = q_keys.size(); bb = n_b2b;
    cpu_rdy = 1'b0;
    for (int i = 0; i < 5; i++) begin
      send_byte(w_bytes[i], 1'b1, t0);
      if (i == 3) check("t5_ovf_at4", 32'(overflow), 32'd0);
    end
    idle(100);
    check("t5_ovf", 32'(overflow), 32'd1);
    check("t5_stalled", q_keys.size() - bk, 0);
    cpu_rdy = 1'b1;
    idle(40);
    check("t5_npulse", q_keys.size() - bk, 4);
    for (int i = 0; i < 4; i++) begin
      if (q_keys.size() > bk + i) check($sformatf("t5_key%0d", i), 32'(q_keys[bk + i]), 32'(exp_keys[i]));
    end
    check("t5_b2b", n_b2b - bb, 0);
    check("t5_ovf_sticky", 32'(overflow), 32'd1);

    // 6: reset during data bit 3 of 'w', then 's'
    @(posedge clk); #1;
    rxd = 1'b0;
    idle(BIT_CLKS);
    for (int i = 0; i < 3; i++) begin
      rxd = b6[i];
      idle(BIT_CLKS);
    end
    rxd = b6[3];
    idle(BIT_CLKS / 2);
    check("t6_busy_pre", 32'(rx_busy), 32'd1);
    rst = 1'b1;
    rxd = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    check("t6_we", 32'(SPART_we), 32'd0);
    check("t6_keys", 32'(SPART_keys), 32'd0);
    check("t6_ferr", 32'(frame_err), 32'd0);
    check("t6_ovf", 32'(overflow), 32'd0);
    check("t6_busy", 32'(rx_busy), 32'd0);
    bk = q_keys.size(); bf = n_ferr;
    idle(200);
    send_byte(8'h73, 1'b1, t0);
    idle(100);
    check("t6_npulse", q_keys.size() - bk, 1);
    if (q_keys.size() > bk) check("t6_key", 32'(q_keys[bk]), 32'd2);
    check("t6_ferr_cnt", n_ferr - bf, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
